// File: rtl/fetch_unit_pkg.sv
// Shared front-end constants and fetch FSM state encodings.
package fetch_unit_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT_LO = 2'd0,
    BOOT_HI = 2'd1,
    RUN     = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {instruction, pc} pairs ahead of decode.
module fetch_queue #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (w_pop && !w_push) r_count <= r_count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: boots PC from the reset vector, prefetches
// into a 2-entry queue and handles branch/jump redirects.
module fetch_unit #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_VEC_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               flush_fd
);
  import fetch_unit_pkg::*;

  localparam int QW    = INSTR_W + PC_W;
  localparam int PC_HI = PC_W - INSTR_W;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [PC_W-1:0]   w_addr;
  logic              r_flush;
  logic              w_flush_nxt;
  logic              w_rd;
  logic              w_push;
  logic              w_pop;
  logic              w_clear;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_count;
  logic [QW-1:0]     w_head;

  fetch_queue #(.W(QW)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  ({imem_data, r_pc}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr      = r_pc;
    w_rd        = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    w_flush_nxt = 1'b0;
    unique case (r_state)
      BOOT_LO: begin
        w_rd   = 1'b1;
        w_addr = RESET_VEC_ADDR;
        if (imem_ready) begin
          w_pc_nxt    = {r_pc[PC_W-1:INSTR_W], imem_data};
          w_state_nxt = BOOT_HI;
        end
      end
      BOOT_HI: begin
        w_rd   = 1'b1;
        w_addr = RESET_VEC_ADDR + 1'b1;
        if (imem_ready) begin
          w_pc_nxt    = {PC_HI'(imem_data), r_pc[INSTR_W-1:0]};
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // A redirect suppresses the pop so a full queue does not issue a new request.
        w_pop = !stall && (w_count != 2'd0) && !redirect_valid;
        w_rd  = !w_full || w_pop;
        if (redirect_valid) begin
          w_clear     = 1'b1;
          w_pc_nxt    = redirect_pc;
          w_flush_nxt = 1'b1;
        end else if (imem_ready && w_rd) begin
          w_push   = 1'b1;
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      default: w_state_nxt = BOOT_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT_LO;
      r_pc    <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  // Reset must silence the memory port at once, even in the boot states.
  assign imem_rd     = w_rd & ~rst;
  assign imem_addr   = rst ? '0 : w_addr;
  assign instr_valid = ~w_empty;
  assign instr_out   = w_empty ? INSTR_W'(NOP_INSTR) : w_head[QW-1:PC_W];
  assign instr_pc    = w_empty ? '0 : w_head[PC_W-1:0];
  assign flush_fd    = r_flush;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a queue-based behavioural reference model.
module tb_fetch_unit;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;
  localparam logic [PC_W-1:0] RV = 32'd0;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_ready;
  logic               stall = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               flush_fd;
  logic               mem_gate = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    if (a == RV) return 16'h0100;
    if (a == RV + 32'd1) return 16'h0000;
    return a[15:0] ^ {a[7:0], a[31:24]} ^ 16'h3C5A;
  endfunction

  assign imem_data  = mem_word(imem_addr);
  assign imem_ready = imem_rd & mem_gate;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_VEC_ADDR(RV)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .imem_data      (imem_data),
    .imem_ready     (imem_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .flush_fd       (flush_fd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: boot word counter, PC, and a FIFO of fetched words.
  typedef struct packed {
    logic [INSTR_W-1:0] ins;
    logic [PC_W-1:0]    pc;
  } ent_t;
  ent_t            mq[$];
  int              m_boot  = 0;
  logic [PC_W-1:0] m_pc    = '0;
  bit              m_flush = 1'b0;
  logic            e_rd;
  logic            e_pop;
  logic            e_rdy;
  logic [PC_W-1:0] e_addr;

  always @(negedge clk) begin
    e_pop  = 1'b0;
    e_rd   = 1'b0;
    e_addr = '0;
    if (!rst) begin
      if (m_boot == 0) begin
        e_rd = 1'b1; e_addr = RV;
      end else if (m_boot == 1) begin
        e_rd = 1'b1; e_addr = RV + 32'd1;
      end else begin
        e_pop  = !stall && mq.size() > 0 && !redirect_valid;
        e_rd   = (mq.size() < 2) || e_pop;
        e_addr = m_pc;
      end
    end
    check("imem_rd", imem_rd, e_rd);
    check("imem_addr", imem_addr, e_addr);
    if (!rst && mq.size() > 0) begin
      check("instr_valid", instr_valid, 1);
      check("instr_out", instr_out, mq[0].ins);
      check("instr_pc", instr_pc, mq[0].pc);
    end else begin
      check("instr_valid", instr_valid, 0);
      check("instr_out", instr_out, 0);
      check("instr_pc", instr_pc, 0);
    end
    check("flush_fd", flush_fd, (!rst && m_flush));

    if (rst) begin
      m_boot = 0; m_pc = '0; m_flush = 1'b0; mq.delete();
    end else begin
      e_rdy = e_rd && mem_gate;
      if (m_boot == 0) begin
        m_flush = 1'b0;
        if (e_rdy) begin m_pc[15:0] = mem_word(RV); m_boot = 1; end
      end else if (m_boot == 1) begin
        m_flush = 1'b0;
        if (e_rdy) begin m_pc[31:16] = mem_word(RV + 32'd1); m_boot = 2; end
      end else begin
        m_flush = redirect_valid;
        if (redirect_valid) begin
          mq.delete();
          m_pc = redirect_pc;
        end else begin
          if (e_pop) void'(mq.pop_front());
          if (e_rdy) begin
            mq.push_back('{ins: mem_word(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd1;
          end
        end
      end
    end
  end

  task automatic drive(input bit s, input bit r, input bit g, input logic [PC_W-1:0] p);
    @(posedge clk); #1;
    stall = s; redirect_valid = r; mem_gate = g; redirect_pc = p;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("arst_rd", imem_rd, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_out", instr_out, 0);
    check("arst_pc", instr_pc, 0);
    check("arst_flush", flush_fd, 0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [PC_W-1:0] rpc;
    mem_gate = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    n = 0;
    do begin @(negedge clk); #1; n++; end while (!instr_valid && n < 20);
    check("first_valid_cycle", n, 4);
    check("first_pc", instr_pc, 32'h100);

    repeat (10) drive(0, 0, 1, '0);
    for (int i = 0; i < 24; i++) drive(0, 0, (i % 4 == 3), '0);
    repeat (3) drive(0, 0, 1, '0);

    repeat (5) drive(1, 0, 1, '0);
    @(negedge clk); #1;
    check("stall_rd_low", imem_rd, 0);
    check("stall_valid_held", instr_valid, 1);
    repeat (6) drive(0, 0, 1, '0);

    repeat (3) drive(1, 0, 1, '0);
    drive(1, 1, 1, 32'h200);
    drive(0, 0, 1, '0);
    @(negedge clk); #1;
    check("redir_flush", flush_fd, 1);
    check("redir_queue_dropped", instr_valid, 0);
    n = 1;
    while (!(instr_valid && instr_pc == 32'h200) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("redir_latency", n, 2);
    check("flush_one_cycle", flush_fd, 0);

    repeat (3) drive(0, 0, 1, '0);
    drive(1, 1, 1, 32'h300);
    repeat (5) drive(0, 0, 1, '0);

    drive(0, 1, 1, 32'h400);
    drive(0, 1, 1, 32'h500);
    drive(0, 1, 1, 32'hFFFF_FFFF);
    repeat (6) drive(0, 0, 1, '0);

    for (int i = 0; i < 800; i++) begin
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 2))
                                        : ($urandom() & 32'h0000_0FFF);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 6, rpc);
    end

    drive(0, 0, 0, '0);
    async_reset();
    drive(0, 0, 1, '0);
    repeat (3) drive(0, 0, 0, '0);
    async_reset();
    repeat (12) drive(0, 0, 1, '0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
